// File: rtl/im_loader.sv
// im_loader: turns a framed byte stream into 16-bit instruction memory writes and holds the
// CPU while a load is in progress.
// Frame: header N (0 = 2^ADDR_W words), N {hi, lo} byte pairs, optional XOR checksum byte.
// Define IM_LOADER_CSUM_EN to require and verify the trailing checksum byte.
module im_loader #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [15:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // One extra bit so that a header of 0 can count 2^ADDR_W words.
    localparam int unsigned RemW = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StHi,
        StLo,
        StWrite,
`ifdef IM_LOADER_CSUM_EN
        StCsum,
        StErr,
`endif
        StDone
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [RemW-1:0]   remaining;
    logic [7:0]        hi_byte;
    logic              xfer;

`ifdef IM_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    assign xfer = in_valid && in_ready;

    // Registered {in_ready, cpu_hold, done} for the state being entered.
    function automatic logic [2:0] outs(input state_t s);
        unique case (s)
            StHdr, StHi, StLo: outs = 3'b110;
            StWrite:           outs = 3'b010;
`ifdef IM_LOADER_CSUM_EN
            StCsum:            outs = 3'b110;
            StErr:             outs = 3'b010;
`endif
            StDone:            outs = 3'b001;
            default:           outs = 3'b000;
        endcase
    endfunction

`ifndef IM_LOADER_CSUM_EN
    assign error = 1'b0;
`endif

    // Load sequencer: framing, word assembly, write strobe and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                       <= StIdle;
            {in_ready, cpu_hold, done}  <= 3'b000;
            we                          <= 1'b0;
            waddr                       <= '0;
            wdata                       <= '0;
            addr                        <= '0;
            remaining                   <= '0;
            hi_byte                     <= '0;
`ifdef IM_LOADER_CSUM_EN
            csum                        <= '0;
            error                       <= 1'b0;
`endif
        end else begin
            we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state                      <= StHdr;
                        {in_ready, cpu_hold, done} <= outs(StHdr);
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        remaining <= (in_data == 8'd0) ? (RemW'(1) << ADDR_W) : RemW'(in_data);
                        addr      <= BASE_ADDR;
`ifdef IM_LOADER_CSUM_EN
                        csum      <= '0;
`endif
                        state                      <= StHi;
                        {in_ready, cpu_hold, done} <= outs(StHi);
                    end
                end
                StHi: begin
                    if (xfer) begin
                        hi_byte <= in_data;
`ifdef IM_LOADER_CSUM_EN
                        csum    <= csum ^ in_data;
`endif
                        state                      <= StLo;
                        {in_ready, cpu_hold, done} <= outs(StLo);
                    end
                end
                StLo: begin
                    if (xfer) begin
                        // Strobe goes out during the WRITE cycle that follows.
                        we    <= 1'b1;
                        waddr <= addr;
                        wdata <= {hi_byte, in_data};
`ifdef IM_LOADER_CSUM_EN
                        csum  <= csum ^ in_data;
`endif
                        state                      <= StWrite;
                        {in_ready, cpu_hold, done} <= outs(StWrite);
                    end
                end
                StWrite: begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - RemW'(1);
                    if (remaining == RemW'(1)) begin
`ifdef IM_LOADER_CSUM_EN
                        state                      <= StCsum;
                        {in_ready, cpu_hold, done} <= outs(StCsum);
`else
                        state                      <= StDone;
                        {in_ready, cpu_hold, done} <= outs(StDone);
`endif
                    end else begin
                        state                      <= StHi;
                        {in_ready, cpu_hold, done} <= outs(StHi);
                    end
                end
`ifdef IM_LOADER_CSUM_EN
                StCsum: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state                      <= StDone;
                            {in_ready, cpu_hold, done} <= outs(StDone);
                            error                      <= 1'b0;
                        end else begin
                            state                      <= StErr;
                            {in_ready, cpu_hold, done} <= outs(StErr);
                            error                      <= 1'b1;
                        end
                    end
                end
                StErr: begin
                    // CPU stays held here until a reload succeeds.
                    if (start) begin
                        state                      <= StHdr;
                        {in_ready, cpu_hold, done} <= outs(StHdr);
                        error                      <= 1'b0;
                    end
                end
`endif
                StDone: begin
                    if (start) begin
                        state                      <= StHdr;
                        {in_ready, cpu_hold, done} <= outs(StHdr);
                    end
                end
                default: begin
                    state                      <= StIdle;
                    {in_ready, cpu_hold, done} <= outs(StIdle);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: two instances (BASE_ADDR 0x00 and 0xFF) share one stream;
// expected writes are queued per instance and a negedge monitor pops them on every we.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready0, we0, cpu_hold0, done0, error0;
    logic [7:0]  waddr0;
    logic [15:0] wdata0;
    logic        in_ready1, we1, cpu_hold1, done1, error1;
    logic [7:0]  waddr1;
    logic [15:0] wdata1;

    int total  = 0;
    int passed = 0;

    logic [23:0] exp0[$];
    logic [23:0] exp1[$];
    logic [23:0] e0, e1;

    im_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .cpu_hold(cpu_hold0), .done(done0), .error(error0)
    );

    im_loader #(.ADDR_W(8), .BASE_ADDR(8'hFF)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .cpu_hold(cpu_hold1), .done(done1), .error(error1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the head of that instance's queue.
    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            if (exp0.size() == 0) check("dut0_unexpected_we", 32'(we0), 32'd0);
            else begin
                e0 = exp0.pop_front();
                check("dut0_write", {8'h00, waddr0, wdata0}, {8'h00, e0});
            end
        end
        if (we1 === 1'b1) begin
            if (exp1.size() == 0) check("dut1_unexpected_we", 32'(we1), 32'd0);
            else begin
                e1 = exp1.pop_front();
                check("dut1_write", {8'h00, waddr1, wdata1}, {8'h00, e1});
            end
        end
    end

    // Word offset i from base: instance 0 writes at i, instance 1 at 0xFF + i (mod 256).
    task automatic expect_word(input logic [7:0] off, input logic [15:0] d);
        logic [7:0] a1;
        a1 = off + 8'hFF;
        exp0.push_back({off, d});
        exp1.push_back({a1, d});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready0", 32'(in_ready0), 32'd1);
        check("start_hold0", 32'(cpu_hold0), 32'd1);
        check("start_ready1", 32'(in_ready1), 32'd1);
    endtask

    // Present a byte from a negedge until it is transferred; returns at the next negedge.
    task automatic send(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!acc && n < 20) begin
            acc = in_ready0;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    // Finish a frame after the last low byte; good selects the expected outcome.
    task automatic end_frame(input string tag, input logic [7:0] cs, input logic good);
`ifdef IM_LOADER_CSUM_EN
        send(cs);
        check({tag, "_error0"}, 32'(error0), 32'(!good));
        check({tag, "_error1"}, 32'(error1), 32'(!good));
`else
        @(negedge clk);
        check({tag, "_error0"}, 32'(error0), 32'd0);
        if (cs != 8'h00) check({tag, "_cs_unused"}, 32'(good), 32'd1);
`endif
        check({tag, "_done0"}, 32'(done0), 32'(good));
        check({tag, "_hold0"}, 32'(cpu_hold0), 32'(!good));
        check({tag, "_ready0"}, 32'(in_ready0), 32'd0);
        check({tag, "_done1"}, 32'(done1), 32'(good));
        check({tag, "_hold1"}, 32'(cpu_hold1), 32'(!good));
        check({tag, "_pending0"}, exp0.size(), 32'd0);
        check({tag, "_pending1"}, exp1.size(), 32'd0);
    endtask

    task automatic frame_1234_abcd(input string tag, input logic [7:0] cs, input logic good);
        expect_word(8'h00, 16'h1234);
        expect_word(8'h01, 16'hABCD);
        do_start();
        send(8'h02);
        send(8'h12);
        send(8'h34);
        send(8'hAB);
        send(8'hCD);
        end_frame(tag, cs, good);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;

        // Reset held for two edges with a byte on the bus.
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready0), 32'd0);
        check("rst_we", 32'(we0), 32'd0);
        check("rst_waddr", 32'(waddr0), 32'd0);
        check("rst_wdata", 32'(wdata0), 32'd0);
        check("rst_hold", 32'(cpu_hold0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_error", 32'(error0), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(in_ready0), 32'd0);
        check("idle_hold", 32'(cpu_hold0), 32'd0);
        check("idle_done", 32'(done0), 32'd0);
        in_valid = 1'b0;

        // Good load with a 3-cycle gap between 12 and 34 and a byte offered during WRITE.
        expect_word(8'h00, 16'h1234);
        expect_word(8'h01, 16'hABCD);
        do_start();
        send(8'h02);
        send(8'h12);
        repeat (3) begin
            @(negedge clk);
            check("gap_no_we", 32'(we0), 32'd0);
        end
        send(8'h34);
        check("write_we", 32'(we0), 32'd1);
        check("write_not_ready", 32'(in_ready0), 32'd0);
        check("write_hold", 32'(cpu_hold0), 32'd1);
        send(8'hAB);
        send(8'hCD);
        end_frame("good", 8'h40, 1'b1);

`ifdef IM_LOADER_CSUM_EN
        // Bad checksum: both writes still land, then ERR with CPU held.
        frame_1234_abcd("bad", 8'h41, 1'b0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(error0), 32'd1);
        check("err_hold", 32'(cpu_hold0), 32'd1);
        frame_1234_abcd("reload", 8'h40, 1'b1);
`endif

        // Wrap frame; a start pulse mid-load must be ignored.
        expect_word(8'h00, 16'h0001);
        expect_word(8'h01, 16'h0002);
        do_start();
        send(8'h02);
        send(8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midload_start_ready", 32'(in_ready0), 32'd1);
        send(8'h01);
        send(8'h00);
        send(8'h02);
        end_frame("wrap", 8'h03, 1'b1);

        // Reset after the HI byte: pending write is dropped.
        do_start();
        send(8'h01);
        send(8'h12);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h34;
        @(negedge clk);
        check("midrst_we", 32'(we0), 32'd0);
        check("midrst_ready", 32'(in_ready0), 32'd0);
        check("midrst_hold", 32'(cpu_hold0), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_idle_hold", 32'(cpu_hold0), 32'd0);
        expect_word(8'h00, 16'hBEEF);
        do_start();
        send(8'h01);
        send(8'hBE);
        send(8'hEF);
        end_frame("after_rst", 8'h51, 1'b1);

        // Header 0 loads 256 words; XOR of i and of ~i over 0..255 are both 0.
        for (int i = 0; i < 256; i++) expect_word(8'(i), {8'(i), ~8'(i)});
        do_start();
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(~8'(i));
            if (i == 254) check("n0_not_done_early", 32'(done0), 32'd0);
        end
        end_frame("n0", 8'h00, 1'b1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global guard against a wedged run.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory program loader: the write side of the 8-bit computer's instruction fetch path. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them into the instruction memory write port at consecutive addresses. While a load is in progress it asserts `cpu_hold` to hold the PC and CPU. On completion it releases the CPU, or flags an error if the frame checksum fails.

## Interface
- `ADDR_W`, default 8: instruction memory address width; matches the PC width.
- `BASE_ADDR`, default 0: address of the first word written in every load.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte. A byte is transferred on a cycle where `in_valid && in_ready`.
- `we`  out  1  instruction memory write enable, registered.
- `waddr`  out  ADDR_W  write address, registered.
- `wdata`  out  16  write data `{hi, lo}`, registered.
- `cpu_hold`  out  1  high while the CPU must not fetch.
- `done`  out  1  level; high in DONE.
- `error`  out  1  level; high in ERR.

## Operation
- **Frame format:**
  - Header byte N = word count; N = 0 means 2^ADDR_W words.
  - Then N pairs of bytes, each pair high byte first, then low byte.
  - Then a checksum byte (only when the checksum feature is compiled in).
- **States and transitions:**
  - IDLE → HDR on `start`.
  - HDR → HI on header accept. Loads `remaining` = N and `addr` = BASE_ADDR, and clears `csum`.
  - HI → LO on accept. Latches the high byte and XORs it into `csum`.
  - LO → WRITE on accept. Latches the low byte and XORs it into `csum`.
  - WRITE lasts one cycle with `we` = 1. `addr` increments and `remaining` decrements.
    - If `remaining` was 1, go to CSUM (or straight to DONE when the checksum feature is out).
    - Otherwise go to HI.
  - CSUM → DONE if the accepted byte equals `csum`; → ERR otherwise.
  - DONE or ERR → HDR on `start`.
- **Handshake:**
  - `in_ready` = 1 only in HDR, HI, LO and CSUM.
  - `in_ready` is 0 in IDLE, WRITE, DONE and ERR; bytes presented in those states are not consumed.
  - `in_valid` may drop at any time; the loader waits without limit.
- **Address rule:** `addr` is ADDR_W bits and wraps modulo 2^ADDR_W.
- **Count rule:** `remaining` is ADDR_W+1 bits, so N = 0 loads 2^ADDR_W words.
- **`cpu_hold`:**
  - 1 in HDR, HI, LO, WRITE, CSUM and ERR.
  - 0 in IDLE and DONE.
  - After a failed load the CPU stays held until a successful reload or reset.
- **`start` in HDR through CSUM:** ignored; the load in progress continues.
- **Error behaviour:** words written before a checksum failure remain in memory; the loader does not roll them back.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 0, `we` = 0, `waddr` = 0, `wdata` = 0, `cpu_hold` = 0, `done` = 0, `error` = 0.
- **Reset mid-load:** returns to IDLE on the reset edge and suppresses any pending write.
- **Start latency:** `start` sampled at edge t → `in_ready` = 1 and `cpu_hold` = 1 from cycle t+1.
- **Write latency:** low byte accepted at edge t → `we` = 1 with valid `waddr`/`wdata` during cycle t+1 only. `in_ready` = 0 during that cycle.
- **Throughput:** minimum 3 cycles per word (HI, LO, WRITE).
- **Completion:** `done`/`error` rise the cycle after the checksum byte is accepted, or after the last WRITE when the checksum feature is out. `cpu_hold` falls in the same cycle that `done` rises.

## Configuration
- **`IM_LOADER_CSUM_EN` defined:** the frame carries a trailing checksum byte equal to the XOR of all data bytes (header excluded). A mismatch enters ERR.
- **`IM_LOADER_CSUM_EN` undefined:**
  - No checksum byte; the last WRITE goes directly to DONE.
  - The CSUM state and `csum` register are absent.
  - `error` is tied to 0.

## Test plan
- **Reset:** assert `rst_n` = 0 for 2 cycles with `in_valid` = 1 → all outputs 0 and no `we`. After release, with no `start`, the loader stays in IDLE.
- **Good load (CSUM_EN):** `start`, then bytes 02 12 34 AB CD 40 → two writes: `waddr` 0x00 with `wdata` 0x1234, then `waddr` 0x01 with `wdata` 0xABCD. `done` = 1 and `cpu_hold` = 0 one cycle after byte 40.
- **Bad checksum:** same frame with checksum 41 → both writes occur, then `error` = 1, `done` = 0, `cpu_hold` stays 1. A subsequent `start` plus a good frame reaches DONE.
- **Backpressure and gaps:**
  - Drop `in_valid` for 3 cycles between bytes 12 and 34 → no `we` until byte 34 is accepted, then `we` exactly 1 cycle later.
  - A byte presented during WRITE is not consumed.
- **Address wrap:** with BASE_ADDR = 0xFF, frame 02 00 01 00 02 03 → writes 0x0001 at address 0xFF, then 0x0002 at address 0x00.
- **Reset mid-load:** assert `rst_n` = 0 after the HI byte is accepted → no `we`, state IDLE, `cpu_hold` = 0. A new `start` and a good frame load cleanly from BASE_ADDR.
